// File: rtl/mem_requester_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_pkg
//   Shared definitions for the RAM requester slice.
//   - state_e      : requester FSM encoding (IDLE/WRITE/READ/RESP)
//   - LED_ADDR_DEF : default I/O-space offset of the LED register
//   - SW_ADDR_DEF  : default I/O-space offset of the switch input
// ---------------------------------------------------------------------------
package mem_req_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam int unsigned LED_ADDR_DEF = 32'h00;
   localparam int unsigned SW_ADDR_DEF  = 32'h40;

endpackage

// File: rtl/mem_requester_if.sv
// ---------------------------------------------------------------------------
// mem_requester_if
//   CPU-side load/store request and response bundle.
//   master : request source (drives req_*, receives req_ready and rsp_*)
//   slave  : mem_requester (receives req_*, drives req_ready and rsp_*)
//   req_addr is ADDR_WIDTH+1 bits; the MSB selects I/O space.
// ---------------------------------------------------------------------------
interface mem_requester_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH:0]   req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mem_mmio_decode.sv
// ---------------------------------------------------------------------------
// mem_mmio_decode
//   I/O-space offset decode for the requester: LED register and read mux.
//   clk, reset : clock, synchronous active-high reset
//   io_wr      : an I/O-space store is in its WRITE cycle
//   wr_off     : I/O offset of that store
//   wr_byte    : low byte of the store data
//   rd_off     : I/O offset of the current load
//   sw_in      : board switches
//   led_out    : LED register
//   io_rdata   : I/O load data ({0,sw_in} at SW_ADDR, 0 elsewhere)
//   Only instantiated when MEM_MMIO_EN is defined.
// ---------------------------------------------------------------------------
module mem_mmio_decode
   import mem_req_pkg::*;
#(
   parameter int          DATA_WIDTH = 16,
   parameter int          ADDR_WIDTH = 8,
   parameter int unsigned LED_ADDR   = LED_ADDR_DEF,
   parameter int unsigned SW_ADDR    = SW_ADDR_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_wr,
   input  logic [ADDR_WIDTH-1:0] wr_off,
   input  logic [7:0]            wr_byte,
   input  logic [ADDR_WIDTH-1:0] rd_off,
   input  logic [7:0]            sw_in,
   output logic [7:0]            led_out,
   output logic [DATA_WIDTH-1:0] io_rdata
);

   always_ff @(posedge clk) begin
      if (reset)
         led_out <= '0;
      else if (io_wr && wr_off == ADDR_WIDTH'(LED_ADDR))
         led_out <= wr_byte;
   end

   // Switches are read combinationally; the top registers the result at the
   // edge ending RESP, so sw_in is effectively sampled in RESP.
   always_comb begin
      io_rdata = '0;
      if (rd_off == ADDR_WIDTH'(SW_ADDR))
         io_rdata[7:0] = sw_in;
   end

endmodule

// File: rtl/mem_requester.sv
// ---------------------------------------------------------------------------
// mem_requester
//   Initiator for a sync-write / 1-cycle-registered-read RAM. Takes one
//   load/store at a time, drives the RAM, absorbs read latency and returns
//   load data with a one-cycle rsp_valid pulse.
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : req_valid/req_ready/req_write/req_addr/req_wdata,
//                       rsp_valid/rsp_rdata
//   ram_read_address  : RAM read address (held outside READ)
//   ram_write_address : RAM write address
//   ram_write         : RAM write enable, high only in WRITE for RAM space
//   ram_din           : RAM write data
//   ram_dout          : RAM registered read data
//   sw_in             : board switches (MEM_MMIO_EN only)
//   led_out           : LED register (0 unless MEM_MMIO_EN)
//   Build option MEM_MMIO_EN: enables the LED/switch I/O space. Without it,
//   I/O stores are dropped and I/O loads return 0, with identical timing.
// ---------------------------------------------------------------------------
module mem_requester
   import mem_req_pkg::*;
#(
   parameter int          DATA_WIDTH = 16,
   parameter int          ADDR_WIDTH = 8,
   parameter int unsigned LED_ADDR   = LED_ADDR_DEF,
   parameter int unsigned SW_ADDR    = SW_ADDR_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_requester_if.slave        bus,
   output logic [ADDR_WIDTH-1:0] ram_read_address,
   output logic [ADDR_WIDTH-1:0] ram_write_address,
   output logic                  ram_write,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   input  logic [7:0]            sw_in,
   output logic [7:0]            led_out
);

   state_e                state, state_nxt;
   logic                  accept;
   logic                  io_q;        // latched request targets I/O space
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic [DATA_WIDTH-1:0] io_rdata;
   logic [DATA_WIDTH-1:0] rdata_sel;

   assign accept = bus.req_valid & bus.req_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // ram_write comes straight from registered state, so req_* can never
   // glitch the RAM enable.
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      ram_write     = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid)
               state_nxt = bus.req_write ? ST_WRITE : ST_READ;
         end
         ST_WRITE: begin
            ram_write = ~io_q;
            state_nxt = ST_IDLE;
         end
         ST_READ:  state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // A reset during READ/RESP clears rsp_rdata and suppresses the pulse;
   // a reset during WRITE still lets the RAM sample ram_write at that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         io_q        <= 1'b0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         din_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= (state == ST_RESP);
         if (state == ST_RESP)
            rsp_rdata_q <= rdata_sel;
         if (accept) begin
            io_q <= bus.req_addr[ADDR_WIDTH];
            if (bus.req_write) begin
               wr_addr_q <= bus.req_addr[ADDR_WIDTH-1:0];
               din_q     <= bus.req_wdata;
            end else begin
               rd_addr_q <= bus.req_addr[ADDR_WIDTH-1:0];
            end
         end
      end
   end

   assign ram_read_address  = rd_addr_q;
   assign ram_write_address = wr_addr_q;
   assign ram_din           = din_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign rdata_sel         = io_q ? io_rdata : ram_dout;

`ifdef MEM_MMIO_EN
   logic io_wr;
   assign io_wr = (state == ST_WRITE) && io_q;

   mem_mmio_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LED_ADDR   (LED_ADDR),
      .SW_ADDR    (SW_ADDR)
   ) u_mmio (
      .clk      (clk),
      .reset    (reset),
      .io_wr    (io_wr),
      .wr_off   (wr_addr_q),
      .wr_byte  (din_q[7:0]),
      .rd_off   (rd_addr_q),
      .sw_in    (sw_in),
      .led_out  (led_out),
      .io_rdata (io_rdata)
   );
`else
   // I/O space is dead: stores dropped, loads read 0, switches ignored.
   logic unused_sw;
   assign unused_sw = ^sw_in;
   assign led_out   = '0;
   assign io_rdata  = '0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// ---------------------------------------------------------------------------
// tb_mem_requester
//   Self-checking bench for mem_requester with a behavioural RAM and a
//   reference model (word array + expected-response queue). Expected
//   timing: stores 2 cycles accept-to-accept, loads 3; rsp_valid is high
//   in the cycle two edges after the load accept edge.
// ---------------------------------------------------------------------------
module tb_mem_requester;
   localparam int DW = 16;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   logic [AW-1:0] ram_read_address, ram_write_address;
   logic          ram_write;
   logic [DW-1:0] ram_din, ram_dout;
   logic [7:0]    sw_in, led_out;

   mem_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus),
      .ram_read_address  (ram_read_address),
      .ram_write_address (ram_write_address),
      .ram_write         (ram_write),
      .ram_din           (ram_din),
      .ram_dout          (ram_dout),
      .sw_in             (sw_in),
      .led_out           (led_out)
   );

   function automatic logic [DW-1:0] pat(input int i);
      return DW'(i * 257) ^ 16'h5A5A;
   endfunction

   // Behavioural RAM: sync write, registered read.
   logic          ram_init = 1'b1;
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= pat(i);
      end else if (ram_write) begin
         ram[ram_write_address] <= ram_din;
      end
      ram_dout <= ram[ram_read_address];
   end

   // Monitors: cycle count, RAM write count, response log.
   int            cyc = 0;
   int            wr_cnt = 0;
   logic [DW-1:0] rsp_q[$];
   int            rsp_cyc_q[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (ram_write === 1'b1) wr_cnt <= wr_cnt + 1;
      if (bus.rsp_valid === 1'b1) begin
         rsp_q.push_back(bus.rsp_rdata);
         rsp_cyc_q.push_back(cyc);
      end
   end

   logic [DW-1:0] model_ram [256];
   int checks = 0;
   int failures = 0;

   // Present a request and wait (bounded) for its accept edge; returns #1
   // after that edge with acc = cycle number of the accept.
   task automatic issue(input bit w, input logic [AW:0] a, input logic [DW-1:0] d,
                        input bit drop_after, output int acc, output bit ok);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      ok  = 1'b0;
      acc = -1;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (bus.req_ready === 1'b1) begin
            @(posedge clk); #1;
            acc = cyc;
            ok  = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (drop_after) bus.req_valid = 1'b0;
   endtask

   task automatic run_store(input logic [AW:0] a, input logic [DW-1:0] d, output bit ok);
      int acc;
      issue(1'b1, a, d, 1'b1, acc, ok);
      @(posedge clk); #1;
   endtask

   // Issue a load and report how many pulses came, the first data and its
   // latency in edges after the accept edge.
   task automatic run_load(input logic [AW:0] a, output int n, output logic [DW-1:0] d,
                           output int lat);
      int acc;
      bit ok;
      rsp_q.delete();
      rsp_cyc_q.delete();
      issue(1'b0, a, '0, 1'b1, acc, ok);
      repeat (4) begin @(posedge clk); #1; end
      n   = ok ? rsp_q.size() : -1;
      d   = (n > 0) ? rsp_q[0] : 'x;
      lat = (n > 0) ? rsp_cyc_q[0] - acc : -1;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      sw_in = 8'h00;
      for (int i = 0; i < 256; i++) model_ram[i] = pat(i);
      reset = 1'b1;
      ram_init = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if ({ram_read_address, ram_write_address, ram_din, bus.rsp_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_regs got=%h exp=0",
                  {ram_read_address, ram_write_address, ram_din, bus.rsp_rdata});
      end
      reset = 1'b0;
      ram_init = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL idle_ready c=%0d got=%b exp=1", c, bus.req_ready);
         end
         checks++;
         if (ram_write !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet c=%0d ram_write=%b rsp_valid=%b exp=0/0",
                     c, ram_write, bus.rsp_valid);
         end
         checks++;
         if (led_out !== 8'h00) begin
            failures++; $display("FAIL idle_led c=%0d got=%h exp=00", c, led_out);
         end
      end
   endtask

   task automatic test_store_load();
      int acc, w0;
      bit ok;
      w0 = wr_cnt;
      issue(1'b1, 9'h005, 16'hBEEF, 1'b1, acc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL sl_store_accept timeout exp=accept"); end
      checks++;
      if ({ram_write, bus.req_ready, ram_write_address, ram_din} !== {1'b1, 1'b0, 8'h05, 16'hBEEF}) begin
         failures++;
         $display("FAIL sl_write_cycle got we=%b rdy=%b wa=%h din=%h exp 1/0/05/BEEF",
                  ram_write, bus.req_ready, ram_write_address, ram_din);
      end
      model_ram[8'h05] = 16'hBEEF;
      @(posedge clk); #1;
      checks++;
      if (ram_write !== 1'b0 || bus.req_ready !== 1'b1 || wr_cnt - w0 != 1) begin
         failures++;
         $display("FAIL sl_after_write we=%b rdy=%b writes=%0d exp 0/1/1",
                  ram_write, bus.req_ready, wr_cnt - w0);
      end
      issue(1'b0, 9'h005, '0, 1'b1, acc, ok);
      checks++;
      if (!ok || ram_read_address !== 8'h05 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL sl_read_cycle ok=%b ra=%h rsp_valid=%b exp 1/05/0",
                  ok, ram_read_address, bus.rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL sl_resp_cycle rsp_valid=%b exp=0", bus.rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL sl_rsp_pulse valid=%b data=%h rdy=%b exp 1/BEEF/1",
                  bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 16'hBEEF) begin
         failures++;
         $display("FAIL sl_rsp_hold valid=%b data=%h exp 0/BEEF", bus.rsp_valid, bus.rsp_rdata);
      end
   endtask

   // Held req_valid with alternating store/load at the address extremes.
   task automatic test_back_to_back();
      logic [DW-1:0] exp_d[$];
      int            exp_c[$];
      int            acc, prev_acc, w0, n_st;
      bit            ok, w, prev_w;
      logic [AW:0]   a;
      logic [DW-1:0] d;
      rsp_q.delete();
      rsp_cyc_q.delete();
      w0 = wr_cnt;
      n_st = 0;
      prev_acc = 0;
      prev_w = 1'b0;
      for (int i = 0; i < 24; i++) begin
         w = (i % 2 == 0);
         a = ($urandom_range(0, 1) == 1) ? 9'h0FF : 9'h000;
         d = DW'($urandom);
         issue(w, a, d, 1'b0, acc, ok);
         if (!ok) begin
            checks++; failures++;
            $display("FAIL b2b_accept i=%0d timeout exp=accept", i);
            break;
         end
         if (i > 0) begin
            checks++;
            if (acc - prev_acc != (prev_w ? 2 : 3)) begin
               failures++;
               $display("FAIL b2b_spacing i=%0d got=%0d exp=%0d", i, acc - prev_acc, prev_w ? 2 : 3);
            end
         end
         if (w) begin
            model_ram[a[AW-1:0]] = d;
            n_st++;
         end else begin
            exp_d.push_back(model_ram[a[AW-1:0]]);
            exp_c.push_back(acc + 2);
         end
         prev_acc = acc;
         prev_w = w;
      end
      bus.req_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      checks++;
      if (rsp_q.size() != exp_d.size() || wr_cnt - w0 != n_st) begin
         failures++;
         $display("FAIL b2b_counts rsp=%0d exp=%0d writes=%0d exp=%0d",
                  rsp_q.size(), exp_d.size(), wr_cnt - w0, n_st);
      end
      for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
         checks++;
         if (rsp_q[j] !== exp_d[j] || rsp_cyc_q[j] != exp_c[j]) begin
            failures++;
            $display("FAIL b2b_rsp j=%0d data=%h exp=%h cyc=%0d exp=%0d",
                     j, rsp_q[j], exp_d[j], rsp_cyc_q[j], exp_c[j]);
         end
      end
   endtask

   // Random RAM-space traffic with random idle gaps.
   task automatic test_random();
      logic [DW-1:0] exp_d[$];
      int            exp_c[$];
      int            acc;
      bit            ok, w;
      logic [AW:0]   a;
      logic [DW-1:0] d;
      rsp_q.delete();
      rsp_cyc_q.delete();
      for (int i = 0; i < 30; i++) begin
         w = ($urandom_range(0, 1) == 1);
         a = {1'b0, AW'($urandom_range(0, 255))};
         d = DW'($urandom);
         issue(w, a, d, 1'b1, acc, ok);
         if (!ok) begin
            checks++; failures++;
            $display("FAIL rnd_accept i=%0d timeout exp=accept", i);
            break;
         end
         if (w) model_ram[a[AW-1:0]] = d;
         else begin
            exp_d.push_back(model_ram[a[AW-1:0]]);
            exp_c.push_back(acc + 2);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      repeat (5) begin @(posedge clk); #1; end
      checks++;
      if (rsp_q.size() != exp_d.size()) begin
         failures++; $display("FAIL rnd_count got=%0d exp=%0d", rsp_q.size(), exp_d.size());
      end
      for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
         checks++;
         if (rsp_q[j] !== exp_d[j] || rsp_cyc_q[j] != exp_c[j]) begin
            failures++;
            $display("FAIL rnd_rsp j=%0d data=%h exp=%h cyc=%0d exp=%0d",
                     j, rsp_q[j], exp_d[j], rsp_cyc_q[j], exp_c[j]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int acc, n, lat, w0;
      bit ok;
      logic [DW-1:0] d;
      run_store(9'h010, 16'h1234, ok);
      model_ram[8'h10] = 16'h1234;
      run_load(9'h010, n, d, lat);
      checks++;
      if (n != 1 || d !== 16'h1234) begin
         failures++; $display("FAIL rm_preload n=%0d data=%h exp 1/1234", n, d);
      end
      // Reset while the load sits in READ.
      rsp_q.delete();
      issue(1'b0, 9'h010, '0, 1'b1, acc, ok);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_after_reset c=%0d valid=%b data=%h rdy=%b exp 0/0000/1",
                     c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (rsp_q.size() != 0) begin
         failures++; $display("FAIL rm_no_pulse got=%0d exp=0", rsp_q.size());
      end
      // Reset while a store sits in WRITE: the store still lands.
      w0 = wr_cnt;
      d = DW'($urandom);
      issue(1'b1, 9'h030, d, 1'b1, acc, ok);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_ram[8'h30] = d;
      run_load(9'h030, n, d, lat);
      checks++;
      if (wr_cnt - w0 != 1 || n != 1 || d !== model_ram[8'h30]) begin
         failures++;
         $display("FAIL rm_write_survives writes=%0d n=%0d data=%h exp 1/1/%h",
                  wr_cnt - w0, n, d, model_ram[8'h30]);
      end
   endtask

   task automatic test_mmio();
      int n, lat, w0;
      bit ok;
      logic [DW-1:0] d;
      sw_in = 8'h3C;
      w0 = wr_cnt;
      run_store(9'h100, 16'h00A5, ok);
`ifdef MEM_MMIO_EN
      checks++;
      if (led_out !== 8'hA5 || wr_cnt != w0) begin
         failures++; $display("FAIL io_led led=%h writes=%0d exp A5/0", led_out, wr_cnt - w0);
      end
      run_store(9'h101, 16'h005A, ok);
      checks++;
      if (led_out !== 8'hA5 || wr_cnt != w0) begin
         failures++; $display("FAIL io_other_store led=%h writes=%0d exp A5/0", led_out, wr_cnt - w0);
      end
      run_load(9'h140, n, d, lat);
      checks++;
      if (n != 1 || d !== 16'h003C || lat != 2) begin
         failures++; $display("FAIL io_sw n=%0d data=%h lat=%0d exp 1/003C/2", n, d, lat);
      end
      sw_in = 8'hC3;
      run_load(9'h140, n, d, lat);
      checks++;
      if (n != 1 || d !== 16'h00C3) begin
         failures++; $display("FAIL io_sw2 n=%0d data=%h exp 1/00C3", n, d);
      end
      run_load(9'h141, n, d, lat);
      checks++;
      if (n != 1 || d !== 16'h0000) begin
         failures++; $display("FAIL io_other_load n=%0d data=%h exp 1/0000", n, d);
      end
`else
      checks++;
      if (led_out !== 8'h00 || wr_cnt != w0) begin
         failures++; $display("FAIL noio_store led=%h writes=%0d exp 00/0", led_out, wr_cnt - w0);
      end
      run_load(9'h010, n, d, lat);
      run_load(9'h140, n, d, lat);
      checks++;
      if (n != 1 || d !== 16'h0000 || lat != 2) begin
         failures++; $display("FAIL noio_load n=%0d data=%h lat=%0d exp 1/0000/2", n, d, lat);
      end
`endif
      // RAM word 0 is untouched by any I/O store.
      run_load(9'h000, n, d, lat);
      checks++;
      if (n != 1 || d !== model_ram[8'h00]) begin
         failures++; $display("FAIL io_ram_intact n=%0d data=%h exp 1/%h", n, d, model_ram[8'h00]);
      end
      checks++;
`ifdef MEM_MMIO_EN
      if (led_out !== 8'hA5) begin
         failures++; $display("FAIL io_led_hold got=%h exp=A5", led_out);
      end
`else
      if (led_out !== 8'h00) begin
         failures++; $display("FAIL noio_led_hold got=%h exp=00", led_out);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_mmio();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
